multi_player_reaction_core: RTL
===============================

MULTI_PLAYER_REACTION_CORE -- requirements
Module: multi_player_reaction_core

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of player channels (1..8).
REQ-002 SHALL have parameter TIME_W, default 14, millisecond counter width.
REQ-003 SHALL have parameter TIMEOUT_MS, default 9999, test-phase timeout in ms.
REQ-004 SHALL have parameter PREP_MIN_MS, default 1000, minimum random wait in ms.
REQ-005 SHALL have parameter PREP_SPAN_LOG2, default 11, random wait added as 0..2^PREP_SPAN_LOG2-1 ms.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-007 clock  in  1  system clock; the block has one clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 tick_1khz  in  1  one-cycle pulse per millisecond.
REQ-010 start  in  1  one-cycle start pulse (debounced upstream).
REQ-011 stop  in  N_PLAYERS  per-player stop button level.
REQ-012 state  out  2  IDLE=0, PREP=1, TEST=2, RESULT=3.
REQ-013 countdown  out  TIME_W  ms remaining in PREP.
REQ-014 elapsed  out  TIME_W  ms since TEST entry.
REQ-015 player_time  out  N_PLAYERS*TIME_W  per-player captured time; player i at bits [i*TIME_W +: TIME_W].
REQ-016 player_done  out  N_PLAYERS  player result final.
REQ-017 player_fail  out  N_PLAYERS  false start or timeout.
REQ-018 winner  out  max(1,clog2(N_PLAYERS))  index of fastest valid player.
REQ-019 winner_valid  out  1  winner holds a valid index.
REQ-020 best_time  out  TIME_W  best winning time since reset.
REQ-021 new_best  out  1  one-cycle pulse when best_time improves.

Function
REQ-022 Each stop bit SHALL be rising-edge detected with one register stage; a stop held across round start SHALL NOT count until released and re-pressed.
REQ-023 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every clock and SHALL never reach zero.
REQ-024 IDLE or RESULT with start=1: next state PREP; countdown = PREP_MIN_MS + lfsr[PREP_SPAN_LOG2-1:0]; player_done, player_fail, winner_valid, elapsed cleared; player_time set to all-ones.
REQ-025 start in PREP or TEST SHALL be ignored.
REQ-026 PREP: countdown SHALL decrement by 1 per tick; a tick with countdown==1 SHALL set countdown=0, elapsed=0 and enter TEST next cycle.
REQ-027 Stop edge in PREP from a player not done: player_fail[i]=1, player_done[i]=1, player_time[i] = all-ones.
REQ-028 All players done in PREP: enter RESULT next cycle, winner_valid=0, no TEST phase.
REQ-029 TEST: elapsed SHALL increment by 1 per tick, saturating at all-ones.
REQ-030 Stop edge in TEST from a player not done: player_time[i] = current elapsed (pre-increment if tick in same cycle), player_done[i]=1.
REQ-031 First valid stop in TEST SHALL set winner and winner_valid=1; simultaneous first stops SHALL resolve to the lowest index; later stops SHALL NOT change winner.
REQ-032 Tick in TEST with elapsed==TIMEOUT_MS-1: all not-done players get player_fail=1, player_done=1, player_time all-ones; enter RESULT. Stop edge in that same cycle SHALL be captured as valid, taking priority over timeout.
REQ-033 All players done in TEST: enter RESULT next cycle.
REQ-034 On RESULT entry with winner_valid=1 and winner time < best_time: best_time updated and new_best pulsed for exactly one cycle; equal time SHALL NOT update.
REQ-035 RESULT SHALL hold all outputs until start.
REQ-036 Stop edges in IDLE or RESULT SHALL be ignored.

Reset
REQ-037 reset_n=0 SHALL immediately force: state=IDLE, countdown=0, elapsed=0, player_time all-ones, player_done=0, player_fail=0, winner=0, winner_valid=0, best_time all-ones, new_best=0, LFSR=LFSR_SEED, stop edge registers=0.
REQ-038 reset_n assertion mid-round SHALL abort the round with no best_time update.

Verification
REQ-039 N=2, force LFSR low bits=0, start -> countdown=1000; 1000 ticks -> TEST; stop[1] edge at elapsed=250, stop[0] at 300 -> winner=1, times 300/250, best_time=250, new_best one pulse.
REQ-040 stop[0] edge during PREP -> player_fail=01, time[0]=3FFF; stop[1] at elapsed=180 -> winner=1, winner_valid=1.
REQ-041 Both stop edges same cycle at elapsed=420 -> winner=0, both times 420.
REQ-042 No stops in TEST -> at 9999th tick state=RESULT, player_fail=11, winner_valid=0, best_time unchanged.
REQ-043 stop held high from prior round, start -> no false start; release and press at elapsed=100 -> time 100.
REQ-044 reset_n low in TEST at elapsed=500 -> state=IDLE, all outputs at REQ-037 values same cycle.

Source files
------------

// File: rtl/multi_player_reaction_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : multi_player_reaction_core
//  Brief    : Multi-player reaction timer. A random PREP wait is followed by
//             a TEST phase. Per-player stop times are captured, the fastest
//             valid player is named winner, and the best time is tracked.
//  Revision : 1.0  initial release
// ============================================================================
module multi_player_reaction_core #(
    parameter int          N_PLAYERS      = 2,
    parameter int          TIME_W         = 14,
    parameter int          TIMEOUT_MS     = 9999,
    parameter int          PREP_MIN_MS    = 1000,
    parameter int          PREP_SPAN_LOG2 = 11,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          tick_1khz_i,
    input  logic                                          start_i,
    input  logic [N_PLAYERS-1:0]                          stop_i,
    output logic [1:0]                                    state_o,
    output logic [TIME_W-1:0]                             countdown_o,
    output logic [TIME_W-1:0]                             elapsed_o,
    output logic [N_PLAYERS*TIME_W-1:0]                   player_time_o,
    output logic [N_PLAYERS-1:0]                          player_done_o,
    output logic [N_PLAYERS-1:0]                          player_fail_o,
    output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner_o,
    output logic                                          winner_valid_o,
    output logic [TIME_W-1:0]                             best_time_o,
    output logic                                          new_best_o
);

    localparam int                WIN_W    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam logic [TIME_W-1:0] ALL_ONES = '1;
    localparam logic [15:0]       LFSR_TAP = 16'hB400;  // x^16+x^14+x^13+x^11+1

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREP   = 2'd1,
        S_TEST   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TIME_W-1:0]      countdown_q, countdown_d;
    logic [TIME_W-1:0]      elapsed_q, elapsed_d;
    logic [TIME_W-1:0]      ptime_q [N_PLAYERS];
    logic [TIME_W-1:0]      ptime_d [N_PLAYERS];
    logic [N_PLAYERS-1:0]   done_q, done_d;
    logic [N_PLAYERS-1:0]   fail_q, fail_d;
    logic [WIN_W-1:0]       winner_q, winner_d;
    logic                   wvalid_q, wvalid_d;
    logic [TIME_W-1:0]      best_q, best_d;
    logic                   new_best_q, new_best_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [N_PLAYERS-1:0]   stop_q;

    logic [N_PLAYERS-1:0]   stop_edge;
    logic [N_PLAYERS-1:0]   valid_stop;
    logic [WIN_W-1:0]       win_idx;

    assign stop_edge = stop_i & ~stop_q;

    // Next-state logic: round sequencing, capture, winner and best-time tracking
    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        elapsed_d   = elapsed_q;
        ptime_d     = ptime_q;
        done_d      = done_q;
        fail_d      = fail_q;
        winner_d    = winner_q;
        wvalid_d    = wvalid_q;
        best_d      = best_q;
        new_best_d  = 1'b0;
        valid_stop  = '0;
        win_idx     = '0;
        // Free-running Galois LFSR; the tap mask keeps it out of the zero state
        lfsr_d      = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LFSR_TAP) : {1'b0, lfsr_q[15:1]};

        case (state_q)
            S_IDLE, S_RESULT: begin
                if (start_i) begin
                    state_d     = S_PREP;
                    countdown_d = TIME_W'(PREP_MIN_MS) + TIME_W'(lfsr_q[PREP_SPAN_LOG2-1:0]);
                    elapsed_d   = '0;
                    done_d      = '0;
                    fail_d      = '0;
                    wvalid_d    = 1'b0;
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        ptime_d[i] = ALL_ONES;
                    end
                end
            end

            S_PREP: begin
                // Any press before the go signal is a false start
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (stop_edge[i] && !done_q[i]) begin
                        fail_d[i]  = 1'b1;
                        done_d[i]  = 1'b1;
                        ptime_d[i] = ALL_ONES;
                    end
                end
                if (tick_1khz_i) begin
                    if (countdown_q <= TIME_W'(1)) begin
                        countdown_d = '0;
                        elapsed_d   = '0;
                        state_d     = S_TEST;
                    end else begin
                        countdown_d = countdown_q - TIME_W'(1);
                    end
                end
                // Everyone false-started: skip TEST entirely
                if (&done_d) begin
                    state_d  = S_RESULT;
                    wvalid_d = 1'b0;
                end
            end

            S_TEST: begin
                valid_stop = stop_edge & ~done_q;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (valid_stop[i]) begin
                        ptime_d[i] = elapsed_q;
                        done_d[i]  = 1'b1;
                    end
                end
                // Downward scan leaves the lowest simultaneous index
                for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                    if (valid_stop[i]) begin
                        win_idx = WIN_W'(i);
                    end
                end
                if (!wvalid_q && (|valid_stop)) begin
                    winner_d = win_idx;
                    wvalid_d = 1'b1;
                end
                if (tick_1khz_i) begin
                    // Stops captured above already hold done_d, so they beat the timeout
                    if (elapsed_q == TIME_W'(TIMEOUT_MS - 1)) begin
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            if (!done_d[i]) begin
                                fail_d[i]  = 1'b1;
                                done_d[i]  = 1'b1;
                                ptime_d[i] = ALL_ONES;
                            end
                        end
                        state_d = S_RESULT;
                    end
                    if (elapsed_q != ALL_ONES) begin
                        elapsed_d = elapsed_q + TIME_W'(1);
                    end
                end
                if (&done_d) begin
                    state_d = S_RESULT;
                end
                // Best time only moves on a strict improvement at RESULT entry
                if ((state_d == S_RESULT) && wvalid_d && (ptime_d[winner_d] < best_q)) begin
                    best_d     = ptime_d[winner_d];
                    new_best_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            countdown_q <= '0;
            elapsed_q   <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                ptime_q[i] <= ALL_ONES;
            end
            done_q      <= '0;
            fail_q      <= '0;
            winner_q    <= '0;
            wvalid_q    <= 1'b0;
            best_q      <= ALL_ONES;
            new_best_q  <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            stop_q      <= '0;
        end else begin
            state_q     <= state_d;
            countdown_q <= countdown_d;
            elapsed_q   <= elapsed_d;
            ptime_q     <= ptime_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            winner_q    <= winner_d;
            wvalid_q    <= wvalid_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            lfsr_q      <= lfsr_d;
            stop_q      <= stop_i;
        end
    end

    generate
        for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
            assign player_time_o[g*TIME_W +: TIME_W] = ptime_q[g];
        end
    endgenerate

    assign state_o        = state_q;
    assign countdown_o    = countdown_q;
    assign elapsed_o      = elapsed_q;
    assign player_done_o  = done_q;
    assign player_fail_o  = fail_q;
    assign winner_o       = winner_q;
    assign winner_valid_o = wvalid_q;
    assign best_time_o    = best_q;
    assign new_best_o     = new_best_q;

endmodule
`default_nettype wire
